// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the byte-serial RAM port arbiter.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_IC_READ,
    S_LS_READ,
    S_LS_WRITE,
    S_DONE
  } state_t;

  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_LS = 1'b1
  } grant_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // UART and other memory-mapped I/O live where addr[17:16] == 2'b11.
  function automatic logic is_io(input logic [31:0] addr);
    return (addr & 32'h0003_0000) == 32'h0003_0000;
  endfunction

  function automatic logic [4:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 5'd1;
      SIZE_H:  return 5'd2;
      SIZE_W:  return 5'd4;
      default: return 5'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// Two-way round-robin pick between icache and LSB; combinational, no backpressure of its own.
module mem_rr_arb (
  input  logic ic_valid,
  input  logic ls_valid,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant
);

  // grant/last_grant: 0 = icache, 1 = LSB; on contention favour whoever did not win last.
  always_comb begin
    grant_valid = ic_valid | ls_valid;
    grant       = ls_valid & (~ic_valid | ~last_grant);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Owns the byte-wide RAM port: grants icache/LSB round-robin, then moves one byte per cycle.
// Reads respond N+1 edges after grant, writes N edges; I/O writes stall while io_buffer_full.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int IC_LINE_BYTES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       rollback,
  input  logic                       ic_req_valid,
  input  logic [31:0]                ic_req_addr,
  output logic                       ic_resp_valid,
  output logic [8*IC_LINE_BYTES-1:0] ic_resp_data,
  input  logic                       ls_req_valid,
  input  logic                       ls_req_wr,
  input  logic [1:0]                 ls_req_size,
  input  logic [31:0]                ls_req_addr,
  input  logic [31:0]                ls_req_wdata,
  output logic                       ls_resp_valid,
  output logic [31:0]                ls_resp_rdata,
  input  logic [7:0]                 mem_din,
  output logic [7:0]                 mem_dout,
  output logic [31:0]                mem_a,
  output logic                       mem_wr,
  input  logic                       io_buffer_full
);

  localparam int BUF_BYTES = (IC_LINE_BYTES > 4) ? IC_LINE_BYTES : 4;
  localparam int IC_W      = 8 * IC_LINE_BYTES;
  localparam logic [4:0] IC_N = 5'(IC_LINE_BYTES);

  state_t                 state_q, state_d;
  grant_t                 last_q, last_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [4:0]             n_q, n_d;
  logic [31:0]            base_q, base_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [8*BUF_BYTES-1:0] buf_q, buf_d;
  logic [31:0]            mem_a_q, mem_a_d;
  logic [7:0]             mem_dout_q, mem_dout_d;
  logic                   mem_wr_q, mem_wr_d;
  logic                   ic_resp_valid_q, ic_resp_valid_d;
  logic [IC_W-1:0]        ic_resp_data_q, ic_resp_data_d;
  logic                   ls_resp_valid_q, ls_resp_valid_d;
  logic [31:0]            ls_resp_rdata_q, ls_resp_rdata_d;

  logic        gnt_vld;
  logic        gnt_ls;
  logic [31:0] req_addr;
  logic [4:0]  cnt_inc;
  logic [4:0]  cap_idx;
  logic [31:0] nxt_addr;

  mem_rr_arb u_rr_arb (
    .ic_valid    (ic_req_valid),
    .ls_valid    (ls_req_valid),
    .last_grant  (last_q == GNT_LS),
    .grant_valid (gnt_vld),
    .grant       (gnt_ls)
  );

  assign req_addr = gnt_ls ? ls_req_addr : ic_req_addr;
  assign cnt_inc  = cnt_q + 5'd1;
  assign cap_idx  = cnt_q - 5'd1;
  assign nxt_addr = base_q + {27'd0, cnt_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      last_q          <= GNT_IC;
      cnt_q           <= '0;
      n_q             <= '0;
      base_q          <= '0;
      wdata_q         <= '0;
      buf_q           <= '0;
      mem_a_q         <= '0;
      mem_dout_q      <= '0;
      mem_wr_q        <= 1'b0;
      ic_resp_valid_q <= 1'b0;
      ic_resp_data_q  <= '0;
      ls_resp_valid_q <= 1'b0;
      ls_resp_rdata_q <= '0;
    end else if (rdy) begin
      state_q         <= state_d;
      last_q          <= last_d;
      cnt_q           <= cnt_d;
      n_q             <= n_d;
      base_q          <= base_d;
      wdata_q         <= wdata_d;
      buf_q           <= buf_d;
      mem_a_q         <= mem_a_d;
      mem_dout_q      <= mem_dout_d;
      mem_wr_q        <= mem_wr_d;
      ic_resp_valid_q <= ic_resp_valid_d;
      ic_resp_data_q  <= ic_resp_data_d;
      ls_resp_valid_q <= ls_resp_valid_d;
      ls_resp_rdata_q <= ls_resp_rdata_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    last_d          = last_q;
    cnt_d           = cnt_q;
    n_d             = n_q;
    base_d          = base_q;
    wdata_d         = wdata_q;
    buf_d           = buf_q;
    mem_a_d         = mem_a_q;
    mem_dout_d      = mem_dout_q;
    mem_wr_d        = mem_wr_q;
    ic_resp_valid_d = 1'b0;
    ic_resp_data_d  = ic_resp_data_q;
    ls_resp_valid_d = 1'b0;
    ls_resp_rdata_d = ls_resp_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (!rollback && gnt_vld) begin
          cnt_d   = '0;
          base_d  = req_addr;
          buf_d   = '0;
          mem_a_d = req_addr;
          if (gnt_ls) begin
            last_d  = GNT_LS;
            n_d     = size_bytes(ls_req_size);
            wdata_d = ls_req_wdata;
            if (ls_req_wr) begin
              state_d    = S_LS_WRITE;
              mem_dout_d = ls_req_wdata[7:0];
              mem_wr_d   = !(is_io(req_addr) && io_buffer_full);
            end else begin
              state_d = S_LS_READ;
            end
          end else begin
            last_d  = GNT_IC;
            n_d     = IC_N;
            state_d = S_IC_READ;
          end
        end
      end

      S_IC_READ, S_LS_READ: begin
        if (rollback) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          mem_a_d = '0;
        end else begin
          // mem_din lags the address by one cycle, so cnt_q==k captures byte k-1.
          if (cnt_q != 5'd0) begin
            buf_d[{cap_idx, 3'b000} +: 8] = mem_din;
          end
          if (cnt_q == n_q) begin
            state_d = S_DONE;
            cnt_d   = '0;
            mem_a_d = '0;
            if (state_q == S_IC_READ) begin
              ic_resp_valid_d = 1'b1;
              ic_resp_data_d  = buf_d[IC_W-1:0];
            end else begin
              ls_resp_valid_d = 1'b1;
              ls_resp_rdata_d = buf_d[31:0];
            end
          end else begin
            cnt_d   = cnt_inc;
            mem_a_d = (cnt_inc < n_q) ? nxt_addr : '0;
          end
        end
      end

      S_LS_WRITE: begin
        // mem_wr low here means the current byte is stalled behind a full I/O buffer.
        if (!mem_wr_q) begin
          mem_wr_d = !(is_io(mem_a_q) && io_buffer_full);
        end else if (cnt_inc < n_q) begin
          cnt_d      = cnt_inc;
          mem_a_d    = nxt_addr;
          mem_dout_d = wdata_q[{cnt_inc[1:0], 3'b000} +: 8];
          mem_wr_d   = !(is_io(nxt_addr) && io_buffer_full);
        end else begin
          state_d         = S_DONE;
          cnt_d           = '0;
          mem_a_d         = '0;
          mem_dout_d      = '0;
          mem_wr_d        = 1'b0;
          ls_resp_valid_d = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_a         = mem_a_q;
  assign mem_dout      = mem_dout_q;
  assign mem_wr        = mem_wr_q;
  assign ic_resp_valid = ic_resp_valid_q;
  assign ic_resp_data  = ic_resp_data_q;
  assign ls_resp_valid = ls_resp_valid_q;
  assign ls_resp_rdata = ls_resp_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: requester tasks push expected responses, a negedge monitor checks them.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rollback;
  logic        ic_req_valid;
  logic [31:0] ic_req_addr;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_data;
  logic        ls_req_valid;
  logic        ls_req_wr;
  logic [1:0]  ls_req_size;
  logic [31:0] ls_req_addr;
  logic [31:0] ls_req_wdata;
  logic        ls_resp_valid;
  logic [31:0] ls_resp_rdata;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] data;
    logic        chk;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  exp_t ic_q[$];
  exp_t ls_q[$];
  wr_t  wr_q[$];
  exp_t e;
  wr_t  w;

  logic [7:0] ram [logic [31:0]];

  mem_arbiter #(.IC_LINE_BYTES(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .rollback       (rollback),
    .ic_req_valid   (ic_req_valid),
    .ic_req_addr    (ic_req_addr),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_data   (ic_resp_data),
    .ls_req_valid   (ls_req_valid),
    .ls_req_wr      (ls_req_wr),
    .ls_req_size    (ls_req_size),
    .ls_req_addr    (ls_req_addr),
    .ls_req_wdata   (ls_req_wdata),
    .ls_resp_valid  (ls_resp_valid),
    .ls_resp_rdata  (ls_resp_rdata),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM gated by rdy; contents reloaded on every reset.
  always @(posedge clk) begin
    if (rst) begin
      ram.delete();
      ram[32'h100] = 8'h13;
      ram[32'h101] = 8'h00;
      ram[32'h102] = 8'h50;
      ram[32'h103] = 8'h00;
      ram[32'h1FF] = 8'hFF;
      ram[32'h200] = 8'h80;
      mem_din <= 8'h00;
    end else if (rdy) begin
      if (mem_wr) ram[mem_a] = mem_dout;
      mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ic_resp_valid) begin
        if (ic_q.size() == 0) check("ic_resp_unexpected", 32'd1, 32'd0);
        else begin
          e = ic_q.pop_front();
          check("ic_data", ic_resp_data, e.data);
          check("ic_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (ls_resp_valid) begin
        if (ls_q.size() == 0) check("ls_resp_unexpected", 32'd1, 32'd0);
        else begin
          e = ls_q.pop_front();
          if (e.chk) check("ls_rdata", ls_resp_rdata, e.data);
          check("ls_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (mem_wr) begin
        if (wr_q.size() == 0) check("mem_wr_unexpected", 32'd1, 32'd0);
        else begin
          w = wr_q.pop_front();
          check("wr_addr", mem_a, w.addr);
          check("wr_data", {24'd0, mem_dout}, {24'd0, w.data});
        end
      end
    end
  end

  task automatic do_ic(input logic [31:0] addr, input logic [31:0] data, input int delay);
    bit got;
    @(negedge clk);
    ic_req_valid = 1'b1;
    ic_req_addr  = addr;
    ic_q.push_back('{data, 1'b1, cyc + delay});
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = ic_resp_valid;
    end
    ic_req_valid = 1'b0;
    check("ic_timeout", 32'(got), 32'd1);
  endtask

  task automatic do_ls(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
    bit got;
    int n;
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    @(negedge clk);
    ls_req_valid = 1'b1;
    ls_req_wr    = wr;
    ls_req_size  = size;
    ls_req_addr  = addr;
    ls_req_wdata = wdata;
    ls_q.push_back('{rdata, !wr, cyc + delay});
    if (wr) for (int k = 0; k < n; k++) wr_q.push_back('{addr + 32'(k), wdata[8*k +: 8]});
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = ls_resp_valid;
    end
    ls_req_valid = 1'b0;
    check("ls_timeout", 32'(got), 32'd1);
  endtask

  logic [4:0] io_pat = 5'b01000;
  int         nresp;

  initial begin
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0; io_buffer_full = 1'b0;
    ic_req_valid = 1'b0; ic_req_addr = '0;
    ls_req_valid = 1'b0; ls_req_wr = 1'b0; ls_req_size = 2'b00;
    ls_req_addr = '0; ls_req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'h0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
    check("rst_ic_valid", {31'd0, ic_resp_valid}, 32'h0);
    check("rst_ls_valid", {31'd0, ls_resp_valid}, 32'h0);
    check("rst_ic_data", ic_resp_data, 32'h0);
    check("rst_ls_rdata", ls_resp_rdata, 32'h0);
    rst = 1'b0;

    // Half load straddling 0x1FF/0x200 with rdy dropped for two edges mid-transfer.
    fork
      do_ls(1'b0, 2'b01, 32'h1FF, 32'h0, 32'h0000_80FF, 6);
      begin
        repeat (3) @(negedge clk);
        rdy = 1'b0;
        repeat (2) @(negedge clk);
        rdy = 1'b1;
      end
    join
    do_ls(1'b0, 2'b00, 32'h1FF, 32'h0, 32'h0000_00FF, 3);
    do_ls(1'b0, 2'b11, 32'h100, 32'h0, 32'h0050_0013, 6);

    // Refill aborted by rollback while byte 2 is on the address bus.
    @(negedge clk);
    ic_req_addr  = 32'h100;
    ic_req_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rb_addr_before", mem_a, 32'h102);
    rollback     = 1'b1;
    ic_req_valid = 1'b0;
    @(negedge clk);
    rollback = 1'b0;
    check("rb_addr_after", mem_a, 32'h0);
    nresp = 0;
    repeat (8) begin
      @(negedge clk);
      if (ic_resp_valid) nresp++;
    end
    check("rb_no_resp", 32'(nresp), 32'd0);

    // I/O byte store held off for three edges by a full UART buffer.
    fork
      do_ls(1'b1, 2'b00, 32'h0003_0000, 32'h41, 32'h0, 5);
      begin
        @(negedge clk);
        io_buffer_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("io_wr_pattern", {31'd0, mem_wr}, {31'd0, io_pat[k]});
          if (k == 2) io_buffer_full = 1'b0;
        end
      end
    join

    // Rollback during a store must not disturb it.
    fork
      do_ls(1'b1, 2'b01, 32'h400, 32'h1234, 32'h0, 3);
      begin
        repeat (2) @(negedge clk);
        rollback = 1'b1;
        @(negedge clk);
        rollback = 1'b0;
      end
    join

    // Reset in the middle of a refill.
    @(negedge clk);
    ic_req_addr  = 32'h100;
    ic_req_valid = 1'b1;
    repeat (2) @(negedge clk);
    rst          = 1'b1;
    ic_req_valid = 1'b0;
    @(negedge clk);
    check("rst2_mem_a", mem_a, 32'h0);
    check("rst2_ic_data", ic_resp_data, 32'h0);
    check("rst2_ls_rdata", ls_resp_rdata, 32'h0);
    rst = 1'b0;

    // Simultaneous requests after reset: LSB first, icache after DONE + IDLE.
    fork
      do_ls(1'b1, 2'b10, 32'h200, 32'hDEAD_BEEF, 32'h0, 5);
      do_ic(32'h100, 32'h0050_0013, 12);
    join
    do_ls(1'b0, 2'b10, 32'h200, 32'h0, 32'hDEAD_BEEF, 6);

    repeat (5) @(negedge clk);
    check("ic_q_empty", 32'(ic_q.size()), 32'd0);
    check("ls_q_empty", 32'(ls_q.size()), 32'd0);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
